// File: rtl/vector_alu_lane.sv
// Integer execution lane: single-cycle ADD/SUB/MUL/logic plus optional iterative DIV/REM.
// Define VECTOR_ALU_LANE_DIV_EN to build the restoring divider; otherwise DIV/REM report divide-by-zero.
module vector_alu_lane #(
  parameter int  DATA_WIDTH = 64,
  parameter int  NUM_VREG   = 32,
  localparam int REG_W      = $clog2(NUM_VREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [2:0]            in_op,
  input  logic                  in_signed,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [REG_W-1:0]      in_vreg,
  output logic                  busy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [REG_W-1:0]      out_vreg,
  output logic                  out_dz
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic                  accept, is_div;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [REG_W-1:0]      out_vreg_q, out_vreg_d;
  logic                  out_dz_q, out_dz_d;

  assign is_div   = (in_op == OP_DIV) || (in_op == OP_REM);
  assign accept   = in_vld && in_rdy;
  assign busy     = !in_rdy;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_vreg = out_vreg_q;
  assign out_dz   = out_dz_q;

  // DIV/REM fall to the default: all ones is the divide-by-zero answer when no divider exists
  always_comb begin
    alu_res = '1;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_MUL:  alu_res = in_a * in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      default: alu_res = '1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_vreg_q <= '0;
      out_dz_q   <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_vreg_q <= out_vreg_d;
      out_dz_q   <= out_dz_d;
    end
  end

`ifdef VECTOR_ALU_LANE_DIV_EN
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d, dvsr_q, dvsr_d;
  logic                  qneg_q, qneg_d, rneg_q, rneg_d;
  logic                  op_rem_q, op_rem_d, dz_q, dz_d;
  logic [REG_W-1:0]      div_vreg_q, div_vreg_d;

  logic                  a_neg, b_neg, div_zero, div_ovf, fix_go;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, quo_res, rem_res, div_res;
  logic [DATA_WIDTH:0]   rem_shift, rem_diff;

  assign in_rdy    = (state_q == S_IDLE) && (!out_vld_q || out_rdy);
  assign a_neg     = in_signed && in_a[DATA_WIDTH-1];
  assign b_neg     = in_signed && in_b[DATA_WIDTH-1];
  assign a_mag     = a_neg ? -in_a : in_a;
  assign b_mag     = b_neg ? -in_b : in_b;
  assign div_zero  = (in_b == '0);
  assign div_ovf   = in_signed && (in_a == MIN_VAL) && (in_b == '1);
  assign rem_shift = {rem_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign quo_res   = qneg_q ? -quo_q : quo_q;
  assign rem_res   = rneg_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
  assign div_res   = op_rem_q ? rem_res : quo_res;
  assign fix_go    = (state_q == S_FIX) && (!out_vld_q || out_rdy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      op_rem_q   <= 1'b0;
      dz_q       <= 1'b0;
      div_vreg_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      op_rem_q   <= op_rem_d;
      dz_q       <= dz_d;
      div_vreg_q <= div_vreg_d;
    end
  end

  // Zero divisor and min/-1 skip the iteration and go straight to FIX
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_div) state_d = (div_zero || div_ovf) ? S_FIX : S_DIV;
      S_DIV:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   if (fix_go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    op_rem_d   = op_rem_q;
    dz_d       = dz_q;
    div_vreg_d = div_vreg_q;
    if (state_q == S_IDLE && accept && is_div) begin
      op_rem_d   = (in_op == OP_REM);
      div_vreg_d = in_vreg;
      cnt_d      = CNT_W'(DATA_WIDTH - 1);
      dvsr_d     = b_mag;
      dz_d       = div_zero;
      qneg_d     = 1'b0;
      rneg_d     = 1'b0;
      rem_d      = '0;
      if (div_zero) begin
        quo_d = '1;
        rem_d = {1'b0, in_a};
      end else if (div_ovf) begin
        quo_d = MIN_VAL;
      end else begin
        quo_d  = a_mag;
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
      end
    end else if (state_q == S_DIV) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      if (!rem_diff[DATA_WIDTH]) begin
        rem_d = rem_diff;
        quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift;
        quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q && !out_rdy;
    out_data_d = out_data_q;
    out_vreg_d = out_vreg_q;
    out_dz_d   = out_dz_q;
    if (accept && !is_div) begin
      out_vld_d  = 1'b1;
      out_data_d = alu_res;
      out_vreg_d = in_vreg;
      out_dz_d   = 1'b0;
    end else if (fix_go) begin
      out_vld_d  = 1'b1;
      out_data_d = div_res;
      out_vreg_d = div_vreg_q;
      out_dz_d   = dz_q;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = in_signed;
  assign in_rdy        = !out_vld_q || out_rdy;

  always_comb begin
    out_vld_d  = out_vld_q && !out_rdy;
    out_data_d = out_data_q;
    out_vreg_d = out_vreg_q;
    out_dz_d   = out_dz_q;
    if (accept) begin
      out_vld_d  = 1'b1;
      out_data_d = alu_res;
      out_vreg_d = in_vreg;
      out_dz_d   = is_div;
    end
  end
`endif

endmodule

// File: tb/tb_vector_alu_lane.sv
// Directed bench for vector_alu_lane (DATA_WIDTH=64, NUM_VREG=32).
// Divider checks build only when VECTOR_ALU_LANE_DIV_EN is defined; otherwise the no-divider behaviour is checked.
module tb_vector_alu_lane;
  localparam int W  = 64;
  localparam int NV = 32;
  localparam int RW = $clog2(NV);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_vld, in_rdy, in_signed, busy;
  logic          out_vld, out_rdy, out_dz;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_data;
  logic [RW-1:0] in_vreg, out_vreg;

  int passCount  = 0;
  int checkCount = 0;

  logic [2:0]    bOp  [4] = '{OP_ADD, OP_SUB, OP_OR, OP_MUL};
  logic [W-1:0]  bA   [4] = '{64'd1, 64'd10, 64'hA0, 64'h100};
  logic [W-1:0]  bB   [4] = '{64'd2, 64'd4, 64'h05, 64'h10};
  logic [W-1:0]  bExp [4] = '{64'd3, 64'd6, 64'hA5, 64'h1000};

  vector_alu_lane #(.DATA_WIDTH(W), .NUM_VREG(NV)) dut (
    .clk(clk), .reset(reset),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_vreg(in_vreg), .busy(busy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_vreg(out_vreg), .out_dz(out_dz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Presents one request and holds it until the lane takes it (bounded)
  task automatic applyStimulus(input logic [2:0] op, input logic sgn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [RW-1:0] vreg);
    int waitCyc;
    @(negedge clk);
    in_op = op; in_signed = sgn; in_a = a; in_b = b; in_vreg = vreg; in_vld = 1'b1;
    waitCyc = 0;
    while (!in_rdy && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!in_rdy) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      in_vld = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_vld = 1'b0;
    end
  endtask

  task automatic waitResult(input string tag, input int expLat, input logic [W-1:0] expData,
                            input logic [RW-1:0] expVreg, input logic expDz);
    int cyc;
    int rdyHigh;
    cyc = 0;
    rdyHigh = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!out_vld && in_rdy) rdyHigh++;
    end while (!out_vld && cyc < 200);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
    checkOutput({tag, "_data"}, out_data, expData);
    checkOutput({tag, "_vreg"}, 64'(out_vreg), 64'(expVreg));
    checkOutput({tag, "_dz"}, 64'(out_dz), 64'(expDz));
    checkOutput({tag, "_in_rdy_low"}, 64'(rdyHigh), 64'd0);
  endtask

  initial begin
    int holdBad;
    int rdyBad;
    int staleCnt;
    reset = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; in_op = OP_ADD; in_signed = 1'b0;
    in_a = '0; in_b = '0; in_vreg = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_vld", 64'(out_vld), 64'd0);
    checkOutput("reset_out_data", out_data, 64'd0);
    checkOutput("reset_out_vreg", 64'(out_vreg), 64'd0);
    checkOutput("reset_out_dz", 64'(out_dz), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_rdy", 64'(in_rdy), 64'd1);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);

    applyStimulus(OP_ADD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3);
    waitResult("add_wrap", 1, 64'd0, 5'd3, 1'b0);
    applyStimulus(OP_XOR, 1'b0, 64'hF0, 64'hFF, 5'd4);
    waitResult("xor", 1, 64'h0F, 5'd4, 1'b0);
    applyStimulus(OP_SUB, 1'b0, 64'd5, 64'd7, 5'd8);
    waitResult("sub_wrap", 1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd8, 1'b0);
    applyStimulus(OP_AND, 1'b0, 64'hFF00_FF00_1234_5678, 64'h0FF0_0FF0_FFFF_0000, 5'd31);
    waitResult("and", 1, 64'h0F00_0F00_1234_0000, 5'd31, 1'b0);

    // One request per clock; each result checked the cycle after it is accepted
    @(negedge clk);
    in_op = bOp[0]; in_a = bA[0]; in_b = bB[0]; in_vreg = 5'd1; in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_vld", i), 64'(out_vld), 64'd1);
      checkOutput($sformatf("b2b%0d_data", i), out_data, bExp[i]);
      checkOutput($sformatf("b2b%0d_vreg", i), 64'(out_vreg), 64'(i + 1));
      if (i < 3) begin
        in_op = bOp[i+1]; in_a = bA[i+1]; in_b = bB[i+1]; in_vreg = RW'(i + 2);
      end else begin
        in_vld = 1'b0;
      end
    end

    // Back-pressure: result held, request queued, then released together
    repeat (2) @(negedge clk);
    out_rdy = 1'b0;
    applyStimulus(OP_MUL, 1'b0, 64'd3, 64'd5, 5'd6);
    holdBad = 0;
    rdyBad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_vld || out_data !== 64'd15 || out_vreg !== 5'd6) holdBad++;
      if (in_rdy) rdyBad++;
      if (i == 4) begin
        in_op = OP_ADD; in_a = 64'd10; in_b = 64'd20; in_vreg = 5'd7; in_vld = 1'b1;
      end
    end
    checkOutput("hold_result_stable", 64'(holdBad), 64'd0);
    checkOutput("hold_in_rdy_low", 64'(rdyBad), 64'd0);
    checkOutput("hold_busy", 64'(busy), 64'd1);
    out_rdy = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
    @(negedge clk);
    checkOutput("release_vld", 64'(out_vld), 64'd1);
    checkOutput("release_data", out_data, 64'd30);
    checkOutput("release_vreg", 64'(out_vreg), 64'd7);
    @(negedge clk);
    checkOutput("release_no_dup", 64'(out_vld), 64'd0);

`ifdef VECTOR_ALU_LANE_DIV_EN
    applyStimulus(OP_DIV, 1'b0, 64'd100, 64'd7, 5'd5);
    waitResult("udiv", 66, 64'd14, 5'd5, 1'b0);
    applyStimulus(OP_REM, 1'b0, 64'd100, 64'd7, 5'd5);
    waitResult("urem", 66, 64'd2, 5'd5, 1'b0);
    applyStimulus(OP_DIV, 1'b1, -64'd7, 64'd2, 5'd10);
    waitResult("sdiv", 66, -64'd3, 5'd10, 1'b0);
    applyStimulus(OP_REM, 1'b1, -64'd7, 64'd2, 5'd11);
    waitResult("srem", 66, -64'd1, 5'd11, 1'b0);
    applyStimulus(OP_DIV, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12);
    waitResult("sdiv_ovf", 2, 64'h8000_0000_0000_0000, 5'd12, 1'b0);
    applyStimulus(OP_REM, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13);
    waitResult("srem_ovf", 2, 64'd0, 5'd13, 1'b0);
    applyStimulus(OP_DIV, 1'b0, 64'd9, 64'd0, 5'd14);
    waitResult("div_zero", 2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 1'b1);
    applyStimulus(OP_REM, 1'b0, 64'd9, 64'd0, 5'd15);
    waitResult("rem_zero", 2, 64'd9, 5'd15, 1'b1);

    // Reset in the middle of an iteration must discard the divide entirely
    applyStimulus(OP_DIV, 1'b0, 64'd1000, 64'd3, 5'd2);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_out_vld_in_reset", 64'(out_vld), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_rdy", 64'(in_rdy), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    staleCnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_vld) staleCnt++;
    end
    checkOutput("abort_no_stale", 64'(staleCnt), 64'd0);
`else
    applyStimulus(OP_DIV, 1'b0, 64'd8, 64'd2, 5'd9);
    waitResult("nodiv_div", 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b1);
    applyStimulus(OP_REM, 1'b1, 64'd9, 64'd4, 5'd10);
    waitResult("nodiv_rem", 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 1'b1);
`endif

    applyStimulus(OP_OR, 1'b0, 64'h1, 64'h2, 5'd20);
    waitResult("or_after_div", 1, 64'h3, 5'd20, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vector_alu_lane.md
# vector_alu_lane

Parametrised integer execution lane for the vector pipeline. It sits between the execution-unit issue stage and the lane write-back buffer. It accepts one element operation per handshake and computes add, subtract, multiply, logic, divide or remainder on DATA_WIDTH-bit operands. It returns the result, tagged with its destination vector register, through a back-pressured output register. Divide and remainder run on an iterative multi-cycle divider; all other operations complete in one cycle.

## Interface
- DATA_WIDTH, 64: operand and result width in bits; must be ≥ 8.
- NUM_VREG, 32: number of vector registers. Tag width is REG_W = $clog2(NUM_VREG).
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_vld  in  1  operation request.
- in_rdy  out  1  lane can accept the request this cycle.
- in_op  in  3  operation code:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 REM, 5 AND, 6 OR, 7 XOR.
- in_signed  in  1  selects signed DIV/REM; ignored by all other ops.
- in_a, in_b  in  DATA_WIDTH  operands. For DIV/REM, in_a is the dividend and in_b the divisor.
- in_vreg  in  REG_W  destination register tag.
- busy  out  1  equals !in_rdy; kept for issue-stage compatibility.
- out_vld  out  1  result valid.
- out_rdy  in  1  write-back can take the result.
- out_data  out  DATA_WIDTH  result.
- out_vreg  out  REG_W  tag of the result.
- out_dz  out  1  result came from a divide-by-zero.

## Operation
- An operation is accepted when in_vld && in_rdy.
- in_rdy = (state==IDLE) && (!out_vld || out_rdy).
- FSM states:
  - IDLE: an accepted non-DIV/REM op loads the output register directly; state stays IDLE. An accepted DIV/REM latches operands, tag, op and sign, then goes to DIV.
  - DIV: restoring divider retires one quotient bit per cycle over DATA_WIDTH cycles, tracked by a counter that counts down from DATA_WIDTH-1. When the counter reaches 0, go to FIX.
  - FIX: apply sign correction, then load the output register if it is empty, or if it is being drained this cycle. Otherwise stay in FIX until that is true. Then return to IDLE.
- Arithmetic:
  - ADD, SUB and MUL wrap modulo 2^DATA_WIDTH. MUL returns the low DATA_WIDTH bits of the product.
  - Signed divide divides the magnitudes, then negates the results. The quotient is negative when the operand signs differ. The remainder takes the sign of the dividend.
  - Divide by zero (in_b==0): DIV returns all ones, REM returns in_a, out_dz=1. The early-out path still goes through FIX, one cycle after acceptance, with no iteration.
  - Signed overflow (min / -1): DIV returns min, REM returns 0, out_dz=0. Handled by the early-out path.
- Output register:
  - out_vld rises on load.
  - out_vld, out_data, out_vreg and out_dz stay stable while out_vld && !out_rdy.
  - Cleared on out_rdy when nothing new is loaded that cycle.
- in_op, in_a and the other request fields are don't-care when in_vld=0.
- Reset values: out_vld=0, out_data=0, out_vreg=0, out_dz=0, state=IDLE, counter=0. in_rdy=1 and busy=0 one cycle after reset is released.
- Reset mid-divide aborts the operation; no result is produced.

## Timing
- Single-cycle ops have a latency of 1: accepted at edge N, out_vld=1 after edge N.
- The lane accepts one single-cycle op per clock when out_rdy stays high.
- DIV/REM latency is DATA_WIDTH+2 cycles from acceptance to out_vld: 1 cycle to latch, DATA_WIDTH iteration cycles, 1 FIX cycle. in_rdy stays 0 for that whole period.
- Early-out DIV/REM has a latency of 2.
- When out_vld && out_rdy coincides with a new acceptance, the new result replaces the old one in the same cycle, with no bubble.
- If out_rdy is held low, in_rdy stays low. No request is lost and none is duplicated.

## Configuration
- VECTOR_ALU_LANE_DIV_EN defined: divider and the DIV/FIX states are built as described above.
- Macro undefined: no divider logic is built. DIV/REM complete in 1 cycle with out_data = all ones and out_dz=1. The FSM reduces to IDLE only.

## Test plan
- Single-cycle ops, DATA_WIDTH=64, out_rdy=1:
  - ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> out_data 0, wraps.
  - XOR 0xF0 ^ 0xFF -> 0x0F.
  - Back-to-back issues give one result per cycle with matching out_vreg.
- Unsigned DIV 100/7 with tag 5 -> quotient 14. REM of the same operands -> 2, out_vreg 5. Both appear exactly 66 cycles after acceptance; in_rdy=0 throughout.
- Signed DIV -7/2 -> -3; signed REM -7/2 -> -1.
- Signed DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 after 2 cycles, out_dz=0.
- DIV 9/0 -> all ones, out_dz=1; REM 9/0 -> 9.
- Hold out_rdy=0 for 10 cycles after a MUL 3*5 result: out_data stays 15, in_rdy=0. Release out_rdy with a queued ADD: the next cycle shows the ADD result, with no loss and no duplicate.
- Assert reset during iteration 20 of a divide: out_vld=0 and in_rdy=1 after release, and no stale result ever appears. Macro undefined: DIV 8/2 -> all ones, out_dz=1, latency 1.
